// File: rtl/fetch_sequencer.sv
// Byte-serial instruction fetcher: reads one- or two-byte instructions from a 4K ROM
// and offers each to a consumer with a valid/ready handshake.
module fetch_sequencer #(
    parameter logic [11:0] RESET_PC    = 12'h000,
    parameter logic [7:0]  HALT_OPCODE = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stall,
    input  logic [7:0]  rom_data,
    input  logic        instr_ready,
    input  logic        pc_load,
    input  logic [11:0] pc_load_value,
    output logic [11:0] rom_addr,
    output logic [11:0] pc,
    output logic [7:0]  instr,
    output logic [7:0]  operand,
    output logic        instr_valid,
    output logic        busy,
    output logic        halted
);

    // state | meaning: IDLE wait start | FETCH opcode | OPERAND 2nd byte | ISSUE offer | HALT wait start
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_OPERAND = 3'd2,
        S_ISSUE   = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [7:0]  instr_q, instr_d;
    logic [7:0]  operand_q, operand_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        halted_q, halted_d;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        operand_d = operand_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (!stall) begin
                    instr_d   = rom_data;
                    operand_d = 8'h00;
                    pc_d      = pc_q + 12'd1;
                    // The halt opcode carries no operand, so a resume starts right after it.
                    if (rom_data[7] && (rom_data != HALT_OPCODE)) state_d = S_OPERAND;
                    else                                           state_d = S_ISSUE;
                end
            end
            S_OPERAND: begin
                if (!stall) begin
                    operand_d = rom_data;
                    pc_d      = pc_q + 12'd1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (instr_ready) begin
                    if (instr_q == HALT_OPCODE) begin
                        state_d = S_HALT;
                    end else begin
                        state_d = S_FETCH;
                        if (pc_load) pc_d = pc_load_value;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered copies of the next state.
        valid_d  = (state_d == S_ISSUE);
        busy_d   = (state_d == S_FETCH) || (state_d == S_OPERAND) || (state_d == S_ISSUE);
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= 8'h00;
            operand_q <= 8'h00;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            operand_q <= operand_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            halted_q  <= halted_d;
        end
    end

    assign rom_addr    = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign operand     = operand_q;
    assign instr_valid = valid_q;
    assign busy        = busy_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed sequences, a redirect vector table,
// and a randomized run against a transaction-level fetch model.
module tb_fetch_sequencer;

    localparam logic [7:0] HALT_OP = 8'hFF;

    logic        clk = 1'b0;
    logic        reset, start, stall, instr_ready, pc_load;
    logic [11:0] pc_load_value;
    logic [7:0]  rom_data;
    logic [11:0] rom_addr, pc;
    logic [7:0]  instr, operand;
    logic        instr_valid, busy, halted;

    logic [7:0] rom [0:4095];
    assign rom_data = rom[rom_addr];

    int checks   = 0;
    int failures = 0;

    fetch_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .stall         (stall),
        .rom_data      (rom_data),
        .instr_ready   (instr_ready),
        .pc_load       (pc_load),
        .pc_load_value (pc_load_value),
        .rom_addr      (rom_addr),
        .pc            (pc),
        .instr         (instr),
        .operand       (operand),
        .instr_valid   (instr_valid),
        .busy          (busy),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_issue(input string name, input logic [7:0] ei, input logic [7:0] eo,
                             input logic [11:0] ep);
        chk({name, "_valid"}, 32'(instr_valid), 1);
        chk({name, "_instr"}, 32'(instr), 32'(ei));
        chk({name, "_operand"}, 32'(operand), 32'(eo));
        chk({name, "_pc"}, 32'(pc), 32'(ep));
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_pc"}, 32'(pc), 0);
        chk({name, "_rom_addr"}, 32'(rom_addr), 0);
        chk({name, "_instr"}, 32'(instr), 0);
        chk({name, "_operand"}, 32'(operand), 0);
        chk({name, "_valid"}, 32'(instr_valid), 0);
        chk({name, "_busy"}, 32'(busy), 0);
        chk({name, "_halted"}, 32'(halted), 0);
    endtask

    typedef struct {
        logic [11:0] target;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  e_instr;
        logic [7:0]  e_op;
        logic [11:0] e_pc;
        int          e_lat;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [11:0] t1, mpc, epc, m1;
        logic [7:0]  einstr, eop;
        bit          two, pend, seen, waiting, halt_next;
        int          n, cnt, stalls;

        vecs[0] = '{12'h100, 8'h12, 8'h34, 8'h12, 8'h00, 12'h101, 2};
        vecs[1] = '{12'h200, 8'h80, 8'h01, 8'h80, 8'h01, 12'h202, 3};
        vecs[2] = '{12'hFFE, 8'hFE, 8'h77, 8'hFE, 8'h77, 12'h000, 3};
        vecs[3] = '{12'hFFF, 8'h7F, 8'h55, 8'h7F, 8'h00, 12'h000, 2};
        vecs[4] = '{12'h7FF, 8'h80, 8'hFF, 8'h80, 8'hFF, 12'h801, 3};

        reset = 1'b1; start = 1'b0; stall = 1'b0; instr_ready = 1'b1;
        pc_load = 1'b0; pc_load_value = 12'h000;
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        rom[12'h000] = 8'h75; rom[12'h001] = 8'hC8; rom[12'h002] = 8'h10;
        rom[12'h003] = 8'hFF; rom[12'h004] = 8'h22;
        rom[12'h010] = 8'h9A; rom[12'h011] = 8'h5B;

        #12;
        chk_reset_vals("reset");
        @(negedge clk) reset = 1'b0;
        tick(); tick();
        chk("idle_hold_busy", 32'(busy), 0);
        chk("idle_hold_pc", 32'(pc), 0);

        // One-byte instruction, two edges after start.
        start = 1'b1; tick(); start = 1'b0;
        chk("fetch_busy", 32'(busy), 1);
        chk("fetch_valid", 32'(instr_valid), 0);
        tick();
        chk_issue("one_byte", 8'h75, 8'h00, 12'h001);

        // Two-byte instruction held while the consumer is not ready.
        tick(); instr_ready = 1'b0;
        tick(); tick();
        chk_issue("two_byte", 8'hC8, 8'h10, 12'h003);
        start = 1'b1; stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_issue("hold", 8'hC8, 8'h10, 12'h003);
        end
        start = 1'b0; stall = 1'b0;

        // Halt opcode; pc_load must be ignored on its handshake.
        instr_ready = 1'b1;
        tick(); tick();
        chk_issue("halt_issue", 8'hFF, 8'h00, 12'h004);
        pc_load = 1'b1; pc_load_value = 12'h123;
        tick();
        pc_load = 1'b0;
        chk("halt_halted", 32'(halted), 1);
        chk("halt_busy", 32'(busy), 0);
        chk("halt_valid", 32'(instr_valid), 0);
        chk("halt_pc", 32'(pc), 'h004);
        pc_load = 1'b1; tick(); pc_load = 1'b0;
        chk("halt_stay", 32'(halted), 1);
        chk("halt_stay_pc", 32'(pc), 'h004);
        start = 1'b1; tick(); start = 1'b0;
        chk("resume_addr", 32'(rom_addr), 'h004);
        tick();
        chk_issue("resume", 8'h22, 8'h00, 12'h005);

        // Stall for two cycles in OPERAND.
        pc_load = 1'b1; pc_load_value = 12'h010;
        tick(); pc_load = 1'b0;
        chk("redirect_pc", 32'(pc), 'h010);
        tick();
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("stall_valid", 32'(instr_valid), 0);
            chk("stall_pc", 32'(pc), 'h011);
            chk("stall_operand", 32'(operand), 'h00);
        end
        stall = 1'b0;
        tick();
        chk_issue("after_stall", 8'h9A, 8'h5B, 12'h012);

        // Redirect to the top of the ROM with the operand fetch wrapping.
        rom[12'hFFF] = 8'h88; rom[12'h000] = 8'hAA;
        pc_load = 1'b1; pc_load_value = 12'hFFF; stall = 1'b1;
        tick(); pc_load = 1'b0; stall = 1'b0;
        chk("wrap_addr", 32'(rom_addr), 'hFFF);
        tick(); tick();
        chk_issue("wrap", 8'h88, 8'hAA, 12'h001);

        // Redirect vector table.
        for (int i = 0; i < 5; i++) begin
            t1 = vecs[i].target + 12'd1;
            rom[vecs[i].target] = vecs[i].b0;
            rom[t1] = vecs[i].b1;
            pc_load = 1'b1; pc_load_value = vecs[i].target;
            tick(); pc_load = 1'b0;
            n = 1;
            while (!instr_valid && n < 8) begin
                tick();
                n++;
            end
            chk_issue($sformatf("vec%0d", i), vecs[i].e_instr, vecs[i].e_op, vecs[i].e_pc);
            chk($sformatf("vec%0d_latency", i), n, vecs[i].e_lat);
        end

        // Asynchronous reset in the middle of an operand fetch.
        rom[12'h020] = 8'hC1; rom[12'h021] = 8'h33;
        pc_load = 1'b1; pc_load_value = 12'h020;
        tick(); pc_load = 1'b0;
        tick();
        chk("mid_op_busy", 32'(busy), 1);
        chk("mid_op_pc", 32'(pc), 'h021);
        #2 reset = 1'b1;
        #1 chk_reset_vals("async_reset");
        @(negedge clk) reset = 1'b0;
        tick(); tick(); tick();
        chk("post_reset_idle", 32'(busy), 0);
        chk("post_reset_pc", 32'(pc), 0);

        // Randomized run against a transaction-level model.
        for (int i = 0; i < 4096; i++)
            rom[i] = ($urandom_range(0, 11) == 0) ? HALT_OP : 8'($urandom);
        mpc = 12'h000; epc = 12'h000; einstr = 8'h00; eop = 8'h00;
        waiting = 1'b1; pend = 1'b0; seen = 1'b0; halt_next = 1'b0;
        cnt = 0; stalls = 0; two = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (pend) cnt++;
            if (halt_next) begin
                chk("rnd_halted", 32'(halted), 1);
                chk("rnd_halt_busy", 32'(busy), 0);
                halt_next = 1'b0;
            end
            if (waiting) chk("rnd_wait_valid", 32'(instr_valid), 0);
            if (!seen && !waiting && instr_valid) begin
                einstr = rom[mpc];
                two    = einstr[7] && (einstr != HALT_OP);
                m1     = mpc + 12'd1;
                eop    = two ? rom[m1] : 8'h00;
                epc    = mpc + (two ? 12'd2 : 12'd1);
                chk("rnd_latency", cnt, 2 + int'(two) + stalls);
                seen = 1'b1;
                pend = 1'b0;
            end
            if (seen) chk_issue("rnd", einstr, eop, epc);
            if (pend && cnt > 60) begin
                chk("rnd_timeout", 32'(instr_valid), 1);
                pend = 1'b0;
            end

            stall         = ($urandom_range(0, 2) == 0);
            start         = ($urandom_range(0, 3) == 0);
            instr_ready   = 1'($urandom_range(0, 1));
            pc_load       = 1'($urandom_range(0, 1));
            pc_load_value = 12'($urandom);
            if (seen && instr_ready) begin
                seen = 1'b0;
                if (einstr == HALT_OP) begin
                    mpc = epc;
                    halt_next = 1'b1;
                    waiting = 1'b1;
                end else begin
                    mpc = pc_load ? pc_load_value : epc;
                    pend = 1'b1; cnt = 0; stalls = 0;
                end
            end else if (waiting && start) begin
                waiting = 1'b0;
                pend = 1'b1; cnt = 0; stalls = 0;
            end else if (pend && stall) begin
                stalls++;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
